// File: rtl/magcomp_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
package magcomp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_e;

    typedef logic [1:0] res_t;

    localparam res_t RES_NONE = 2'b00;
    localparam res_t RES_GT   = 2'b01;
    localparam res_t RES_LT   = 2'b10;
    localparam res_t RES_EQ   = 2'b11;

    // Never returns less than 1 so a single-slice index still has a bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/magcomp_chunk.sv
// Combinational CHUNK-bit unsigned comparator; one slice of the sequential compare.
module magcomp_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    output logic             gt_o,
    output logic             lt_o,
    output logic             eq_o
);

    assign gt_o = (a_i >  b_i);
    assign lt_o = (a_i <  b_i);
    assign eq_o = (a_i == b_i);

endmodule

// File: rtl/seq_magcomp.sv
// Multi-cycle magnitude comparator: walks operand slices MSB-first, stops on the
// first difference, and holds the registered result until the next start.
module seq_magcomp
    import magcomp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             greater,
    output logic             less,
    output logic             equal
);

    localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
    localparam int NCHUNK     = WIDTH / CHUNK_SAFE;
    localparam int IDXW       = clog2(NCHUNK);
    localparam int NSLOT      = 1 << IDXW;

    generate
        if (CHUNK < 1) begin : g_bad_chunk
            $error("seq_magcomp: CHUNK must be at least 1");
        end else if ((WIDTH % CHUNK_SAFE) != 0) begin : g_bad_width
            $error("seq_magcomp: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    res_t             res_q, res_d;
    logic             done_q, done_d;

    // Slice table padded to a power of two so idx_q can never select outside it.
    logic [CHUNK_SAFE-1:0] a_sl [NSLOT];
    logic [CHUNK_SAFE-1:0] b_sl [NSLOT];

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slice
            if (gi < NCHUNK) begin : g_real
                assign a_sl[gi] = a_q[WIDTH-1-CHUNK_SAFE*gi -: CHUNK_SAFE];
                assign b_sl[gi] = b_q[WIDTH-1-CHUNK_SAFE*gi -: CHUNK_SAFE];
            end else begin : g_pad
                assign a_sl[gi] = '0;
                assign b_sl[gi] = '0;
            end
        end
    endgenerate

    logic sl_gt, sl_lt, sl_eq;

    magcomp_chunk #(
        .CHUNK (CHUNK_SAFE)
    ) u_chunk (
        .a_i  (a_sl[idx_q]),
        .b_i  (b_sl[idx_q]),
        .gt_o (sl_gt),
        .lt_o (sl_lt),
        .eq_o (sl_eq)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            idx_q   <= '0;
            res_q   <= RES_NONE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        idx_d   = idx_q;
        res_d   = res_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    sgn_d   = signed_mode;
                    idx_d   = '0;
                    res_d   = RES_NONE;
                    state_d = CMP;
                end
            end
            CMP: begin
                // Opposite signs settle a signed compare before any slice is examined.
                if (sgn_q && (idx_q == '0) && (a_q[WIDTH-1] != b_q[WIDTH-1])) begin
                    res_d   = a_q[WIDTH-1] ? RES_LT : RES_GT;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (!sl_eq) begin
                    res_d   = sl_gt ? RES_GT : (sl_lt ? RES_LT : RES_NONE);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (idx_q == IDXW'(NCHUNK - 1)) begin
                    res_d   = RES_EQ;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q == CMP);
    assign done    = done_q;
    assign greater = (res_q == RES_GT);
    assign less    = (res_q == RES_LT);
    assign equal   = (res_q == RES_EQ);

endmodule

// File: tb/tb_seq_magcomp.sv
// Directed bench for seq_magcomp: one 16-bit instance per slice width (4, 1, 8, 16)
// sharing stimulus, with hand-computed result flags and done-cycle latencies.
module tb_seq_magcomp;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_mode;
    logic [15:0] op_a, op_b;

    // Index 0: CHUNK=4, 1: CHUNK=1, 2: CHUNK=8, 3: CHUNK=16
    logic [3:0] busy_v, done_v, gt_v, lt_v, eq_v;
    int         ch_w [4] = '{4, 1, 8, 16};

    int         n_vec = 0;
    int         n_err = 0;
    int         done_cyc [4];
    logic [2:0] flg [4];
    logic       hs_err [4];

    localparam logic [2:0] F_GT = 3'b100;
    localparam logic [2:0] F_LT = 3'b010;
    localparam logic [2:0] F_EQ = 3'b001;

    always #5 clk = ~clk;

    seq_magcomp #(.WIDTH(16), .CHUNK(4)) u_c4 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .A(op_a), .B(op_b),
        .busy(busy_v[0]), .done(done_v[0]), .greater(gt_v[0]), .less(lt_v[0]), .equal(eq_v[0]));
    seq_magcomp #(.WIDTH(16), .CHUNK(1)) u_c1 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .A(op_a), .B(op_b),
        .busy(busy_v[1]), .done(done_v[1]), .greater(gt_v[1]), .less(lt_v[1]), .equal(eq_v[1]));
    seq_magcomp #(.WIDTH(16), .CHUNK(8)) u_c8 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .A(op_a), .B(op_b),
        .busy(busy_v[2]), .done(done_v[2]), .greater(gt_v[2]), .less(lt_v[2]), .equal(eq_v[2]));
    seq_magcomp #(.WIDTH(16), .CHUNK(16)) u_c16 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .A(op_a), .B(op_b),
        .busy(busy_v[3]), .done(done_v[3]), .greater(gt_v[3]), .less(lt_v[3]), .equal(eq_v[3]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] st0();
        return {busy_v[0], done_v[0], gt_v[0], lt_v[0], eq_v[0]};
    endfunction

    task automatic chk(input string tag, input logic [4:0] exp);
        n_vec++;
        assert (st0() === exp) else begin
            n_err++;
            $error("FAIL %s: busy/done/gt/lt/eq got %b expected %b", tag, st0(), exp);
        end
    endtask

    // Start is high for exactly one cycle (cycle 0); returns positioned in cycle 1.
    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic s);
        op_a        = a;
        op_b        = b;
        signed_mode = s;
        start       = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Records the done cycle and flags of each instance over a bounded window and
    // flags any handshake irregularity (busy gaps, repeated done, flags changing).
    task automatic observe();
        logic [2:0] f;
        for (int i = 0; i < 4; i++) begin
            done_cyc[i] = 0;
            flg[i]      = 3'b000;
            hs_err[i]   = 1'b0;
        end
        for (int c = 1; c <= 19; c++) begin
            for (int i = 0; i < 4; i++) begin
                f = {gt_v[i], lt_v[i], eq_v[i]};
                if (done_cyc[i] == 0) begin
                    if (done_v[i]) begin
                        done_cyc[i] = c;
                        flg[i]      = f;
                        if (busy_v[i]) hs_err[i] = 1'b1;
                    end else if (!busy_v[i] || f != 3'b000) begin
                        hs_err[i] = 1'b1;
                    end
                end else if (done_v[i] || busy_v[i] || f !== flg[i]) begin
                    hs_err[i] = 1'b1;
                end
            end
            tick();
        end
    endtask

    task automatic run_vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic s, input logic [2:0] exp_f,
                           input int e4, input int e1, input int e8, input int e16);
        int exp_c [4];
        exp_c = '{e4, e1, e8, e16};
        launch(a, b, s);
        observe();
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            assert (done_cyc[i] === exp_c[i]) else begin
                n_err++;
                $error("FAIL %s chunk%0d latency: done cycle %0d expected %0d", tag, ch_w[i], done_cyc[i], exp_c[i]);
            end
            n_vec++;
            assert (flg[i] === exp_f) else begin
                n_err++;
                $error("FAIL %s chunk%0d flags gt/lt/eq: got %b expected %b", tag, ch_w[i], flg[i], exp_f);
            end
            n_vec++;
            assert (hs_err[i] === 1'b0) else begin
                n_err++;
                $error("FAIL %s chunk%0d handshake: irregular busy/done/flags (got 1 expected 0)", tag, ch_w[i]);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        op_a        = '0;
        op_b        = '0;
        tick();
        tick();
        chk("reset_state", 5'b00000);
        rst = 1'b0;
        tick();

        //       tag          A        B        sgn   flags  c4  c1  c8  c16
        run_vec("eq_1234",   16'h1234, 16'h1234, 1'b0, F_EQ, 5, 17, 3, 2);
        run_vec("u_9000",    16'h9000, 16'h1FFF, 1'b0, F_GT, 2,  2, 2, 2);
        run_vec("s_9000",    16'h9000, 16'h1FFF, 1'b1, F_LT, 2,  2, 2, 2);
        run_vec("u_12A0",    16'h12A0, 16'h12B0, 1'b0, F_LT, 4, 13, 3, 2);
        run_vec("s_FFFF",    16'hFFFF, 16'hFFFE, 1'b1, F_GT, 5, 17, 3, 2);
        run_vec("u_0005",    16'h0005, 16'h0003, 1'b0, F_GT, 5, 15, 3, 2);
        run_vec("s_8000",    16'h8000, 16'h8001, 1'b1, F_LT, 5, 17, 3, 2);
        run_vec("s_7FFF",    16'h7FFF, 16'h8000, 1'b1, F_GT, 2,  2, 2, 2);
        run_vec("u_7FFF",    16'h7FFF, 16'h8000, 1'b0, F_LT, 2,  2, 2, 2);
        run_vec("s_00F0",    16'h00F0, 16'h0070, 1'b1, F_GT, 4, 10, 3, 2);
        run_vec("u_0001",    16'h0001, 16'h0002, 1'b0, F_LT, 5, 16, 3, 2);
        run_vec("s_FFFF_0",  16'hFFFF, 16'h0000, 1'b1, F_LT, 2,  2, 2, 2);

        // Start while busy is ignored; start in the done cycle is accepted.
        launch(16'h0001, 16'h0002, 1'b0);
        chk("hs_c1", 5'b10000);
        tick();
        op_a  = 16'hFFFF;
        start = 1'b1;
        chk("hs_c2", 5'b10000);
        tick();
        start = 1'b0;
        chk("hs_c3", 5'b10000);
        tick();
        chk("hs_c4", 5'b10000);
        tick();
        chk("hs_c5_done_lt", 5'b01010);
        op_a  = 16'h0005;
        op_b  = 16'h0003;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("hs_c6_restart", 5'b10000);
        tick();
        chk("hs_c7", 5'b10000);
        tick();
        chk("hs_c8", 5'b10000);
        tick();
        chk("hs_c9", 5'b10000);
        tick();
        chk("hs_c10_done_gt", 5'b01100);
        tick();
        chk("hs_c11_hold_gt", 5'b00100);
        repeat (20) tick();

        // Asynchronous reset in the middle of an equal-operand compare.
        launch(16'h1234, 16'h1234, 1'b0);
        tick();
        #2 rst = 1'b1;
        #1 chk("rst_async", 5'b00000);
        #2 rst = 1'b0;
        tick();
        for (int k = 3; k <= 8; k++) begin
            chk($sformatf("rst_quiet_c%0d", k), 5'b00000);
            tick();
        end
        run_vec("after_rst", 16'h0005, 16'h0003, 1'b0, F_GT, 5, 15, 3, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_magcomp.md
Name: seq_magcomp

Overview:
Parametrised, multi-cycle magnitude comparator that generalises the team's 4-bit combinational comparator.
- Compares two WIDTH-bit operands one CHUNK-bit slice per cycle, MSB slice first.
- Supports unsigned or two's-complement signed mode.
- Terminates early on the first differing slice.
- Uses a start/busy/done handshake and holds registered greater/less/equal results until the next start.
- Sits as a shared compare resource in datapaths that cannot afford a wide single-cycle comparator.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits compared per cycle; 1 <= CHUNK <= WIDTH.
NCHUNK, WIDTH/CHUNK, derived slice count; local, not overridable.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  asynchronous, active-high reset.
start  in  1  request; sampled only in IDLE.
signed_mode  in  1  0 = unsigned, 1 = two's-complement; latched with the operands.
A  in  WIDTH  operand A; latched on an accepted start.
B  in  WIDTH  operand B; latched on an accepted start.
busy  out  1  high while in CMP.
done  out  1  one-cycle pulse: result valid.
greater  out  1  A > B.
less  out  1  A < B.
equal  out  1  A == B.

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- Reset (asserted at any time, including mid-compare):
  - state IDLE;
  - busy, done, greater, less, equal all 0;
  - latched operands and slice index 0.
  - All-zero result flags mean "no result".
- States:
  - IDLE: start=1 latches A, B and signed_mode, clears greater/less/equal to 0, sets index=0, then goes to CMP.
  - CMP: busy=1. Each cycle compares slice index (bits WIDTH-1-CHUNK*index down to WIDTH-CHUNK*(index+1)) unsigned.
    - Slices differ: set greater or less from the slice compare and go to IDLE with done=1 next cycle.
    - Slices equal and index=NCHUNK-1: set equal and go to IDLE with done=1.
    - Otherwise: index+1, stay in CMP.
  - Signed mode, first CMP cycle only: if the sign bits (A[WIDTH-1], B[WIDTH-1]) differ, the result is resolved immediately (A sign 1 gives less, else greater). Otherwise the slice compare proceeds unchanged; same-sign two's-complement ordering equals unsigned ordering.
- Timing (start high in cycle 0):
  - busy is high from cycle 1.
  - First differing slice i (or NCHUNK-1 if equal) means done=1 in cycle i+2, with busy low in that cycle.
  - Best case done in cycle 2; worst case in cycle NCHUNK+1.
  - CHUNK=WIDTH gives fixed 2-cycle latency.
- Result flags:
  - Exactly one flag is high from the done cycle until the next accepted start or reset.
  - Flags are never X.
- start while busy: ignored. Operands are not re-latched and there is no queueing.
- start in the done cycle: accepted, because the state is already IDLE. Flags clear the next cycle; done stays a single-cycle pulse.
- A and B may change freely after acceptance; the compare uses latched copies only.
- Elaboration error if WIDTH % CHUNK != 0 or CHUNK < 1.

Decomposition:
- Package magcomp_pkg:
  - state enum (IDLE, CMP);
  - result encoding constants (RES_NONE, RES_GT, RES_LT, RES_EQ);
  - function clog2 for the index width.
- Sub-module magcomp_chunk: purely combinational CHUNK-bit unsigned comparator with outputs gt/lt/eq. It is the parametrised form of the existing 4-bit comparator and is instantiated once; the slice is muxed in by index.

Test Plan:
- WIDTH=16, CHUNK=4, unsigned, A=0x1234, B=0x1234 -> busy in cycles 1-4; done=1 and equal=1 in cycle 5; greater=less=0.
- A=0x9000, B=0x1FFF: unsigned -> greater=1, done in cycle 2; repeat with signed_mode=1 -> less=1, done in cycle 2.
- A=0x12A0, B=0x12B0 unsigned -> less=1, done in cycle 4 (slice 2). Signed A=0xFFFF, B=0xFFFE -> greater=1, done in cycle 5.
- Handshake:
  - start with A=0x0001, B=0x0002, then start in cycle 2 with A=0xFFFF -> second start ignored, result less=1 in cycle 5.
  - New start in that done cycle -> accepted, flags 0 in cycle 6, busy=1.
- Reset: rst pulsed in cycle 2 of an equal-operand compare -> busy/done/flags 0 immediately, no done pulse follows; next start A=0x0005, B=0x0003 -> greater=1, done in cycle 5.
- Parameter sweep: CHUNK=1, 8, 16 with random operand pairs -> flags match the reference ordering in both modes; done latency equals first differing slice index+2.
